// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and bit-period helper.
// Consumers may be built with UART_RX_PARITY_EN to select 8E1 framing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Clocks per line bit; both directions must agree on this value.
    function automatic int calc_scale(input int clk_mhz, input int boadrate);
        return (clk_mhz * 1000 * 1000) / boadrate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; reset value is a parameter.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_tx_writer.sv
// UART transmitter, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
module uart_tx_writer
    import uart_pkg::*;
#(
    parameter int clk_mhz  = 50,
    parameter int boadrate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy
);

    localparam int SCALE = calc_scale(clk_mhz, boadrate);
    localparam int CNT_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SCALE - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == TX_IDLE) ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    shift_d = din;
                    tx_d    = 1'b0;
                    cnt_d   = CNT_FULL;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                    cnt_d   = CNT_FULL;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    cnt_d = CNT_FULL;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = TX_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    cnt_d   = CNT_FULL;
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != TX_IDLE);

endmodule

// File: rtl/uart_rx_reader.sv
// UART receiver with a one-entry valid/ready output register, frame and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err reporting; default is 8N1.
module uart_rx_reader
    import uart_pkg::*;
#(
    parameter int clk_mhz  = 50,
    parameter int boadrate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int SCALE = calc_scale(clk_mhz, boadrate);
    localparam int HALF  = SCALE / 2;
    localparam int CNT_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SCALE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    logic rx_s;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             commit;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             parity_err_q, parity_err_d;
    logic             parity_ok;

    assign parity_ok = ~^{shift_q, par_bit_q};
`endif

    assign tick = (cnt_q == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == IDLE || state_q == RECOVER) ? cnt_q : cnt_q - 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = CNT_FULL;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bit_d = rx_s;
                    cnt_d     = CNT_FULL;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = !parity_ok;
`endif
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        commit = parity_ok;
`else
                        commit = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RECOVER;
                    end
                end
            end
            RECOVER: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Single-entry output buffer: a new byte only lands if the old one is gone or leaving.
        if (commit) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign valid     = valid_q;
    assign data      = data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_reader.sv
// Scoreboard bench for uart_rx_reader (scale=10); also loops back uart_tx_writer.
// Honours UART_RX_PARITY_EN for 8E1 framing and the wrong-parity case.
`timescale 1ns/1ps
module tb_uart_rx_reader;

    localparam int CLK_MHZ  = 1;
    localparam int BOADRATE = 100000;
    localparam int SCALE    = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_EXP  = 108;
`else
    localparam int LAT_EXP  = 98;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx;
    logic       rx_drv = 1'b1;
    logic       use_tx = 1'b0;
    logic       ready = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       tx_start = 1'b0;
    logic [7:0] tx_din = 8'h00;
    logic       tx_line;
    logic       tx_busy;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign rx = use_tx ? tx_line : rx_drv;

    uart_rx_reader #(.clk_mhz(CLK_MHZ), .boadrate(BOADRATE)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .valid      (valid),
        .data       (data),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    uart_tx_writer #(.clk_mhz(CLK_MHZ), .boadrate(BOADRATE)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .din   (tx_din),
        .tx    (tx_line),
        .busy  (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and counts flag pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none", data);
                end else begin
                    check("rx_data", 32'(data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (SCALE) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (SCALE) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_drv = (^b) ^ bad_par;
        repeat (SCALE) @(negedge clk);
`else
        if (bad_par) rx_drv = 1'b1;
`endif
        rx_drv = stop_bit;
        repeat (SCALE) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic tx_send(input logic [7:0] b);
        int k;
        @(negedge clk);
        tx_din   = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        k = 0;
        while (tx_busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("tx_busy_timeout", 32'(k), 32'(0));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        idle(4);
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_data", 32'(data), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_parity_err", 32'(parity_err), 32'(0));
        rst = 1'b0;
        idle(5);

        // Two back-to-back bytes with ready high; first one also times the latency.
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        fork
            send_byte(8'hA5, 1'b1, 1'b0);
            begin
                lat = 0;
                @(negedge clk);
                while (!valid && lat < 300) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check("latency", 32'(lat), 32'(LAT_EXP));
            end
        join
        send_byte(8'h3C, 1'b1, 1'b0);
        drain("drain_a5_3c");
        idle(5);
        check("flags_clean_fe", 32'(fe_cnt), 32'(0));
        check("flags_clean_ov", 32'(ov_cnt), 32'(0));

        // Short low glitch on the line.
        rx_drv = 1'b0;
        idle(3);
        rx_drv = 1'b1;
        idle(30);
        check("glitch_valid", 32'(valid), 32'(0));
        check("glitch_fe", 32'(fe_cnt), 32'(0));

        // Bad stop bit, then a good frame.
        send_byte(8'h55, 1'b0, 1'b0);
        idle(5);
        check("frame_err_count", 32'(fe_cnt), 32'(1));
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        drain("drain_12");
        idle(5);

        // Overrun: consumer stalled across two commits.
        ready = 1'b0;
        exp_q.push_back(8'h01);
        send_byte(8'h01, 1'b1, 1'b0);
        idle(5);
        send_byte(8'h02, 1'b1, 1'b0);
        idle(20);
        check("ovr_valid", 32'(valid), 32'(1));
        check("ovr_data", 32'(data), 32'h01);
        check("ovr_count", 32'(ov_cnt), 32'(1));
        @(posedge clk);
        #1;
        ready = 1'b1;
        idle(3);
        check("ovr_drained_valid", 32'(valid), 32'(0));
        check("ovr_queue", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of bit 4 of 8'hFF.
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (SCALE) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4 * SCALE + SCALE / 2) @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
        check("midrst_valid", 32'(valid), 32'(0));
        check("midrst_data", 32'(data), 32'h00);
        idle(SCALE * 6);
        check("midrst_valid_late", 32'(valid), 32'(0));
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 1'b0);
        drain("drain_81");
        idle(5);
        check("midrst_fe", 32'(fe_cnt), 32'(1));
        check("midrst_ov", 32'(ov_cnt), 32'(1));

        // Loopback through the transmitter.
        use_tx = 1'b1;
        idle(5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        tx_send(8'h00);
        tx_send(8'hFF);
        tx_send(8'h5A);
        drain("drain_loopback");
        use_tx = 1'b0;
        idle(10);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h5A, 1'b1, 1'b1);
        idle(10);
        check("parity_err_count", 32'(pe_cnt), 32'(1));
        check("parity_no_valid", 32'(valid), 32'(0));
`else
        check("parity_err_tied", 32'(pe_cnt), 32'(0));
`endif
        check("final_fe", 32'(fe_cnt), 32'(1));
        check("final_ov", 32'(ov_cnt), 32'(1));
        check("final_queue", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_reader.md
UART_RX_READER -- requirements
Module: uart_rx_reader

Interface
- REQ-001 SHALL have parameter clk_mhz, default 50: system clock frequency in MHz.
- REQ-002 SHALL have parameter boadrate, default 9600: line bit rate in bit/s; scale = clk_mhz*1000*1000/boadrate clocks per bit, half = scale/2.
- REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
- REQ-005 SHALL have port rx, input, 1: asynchronous serial line, idle high; frame 8N1, LSB first.
- REQ-006 SHALL have port valid, output, 1: data holds an unconsumed byte.
- REQ-007 SHALL have port data, output, 8: received byte.
- REQ-008 SHALL have port ready, input, 1: consumer accepts data when valid && ready.
- REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse when the stop bit samples 0.
- REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when a completed byte is dropped.
- REQ-011 SHALL have port parity_err, output, 1: one-cycle pulse on parity mismatch (see Configuration).

Function
- REQ-012 SHALL pass rx through a 2-FF synchronizer (reset value 1); all decisions use the synchronized bit rx_s.
- REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, RECOVER, with one bit counter (cnt, width $clog2(scale)) and a 3-bit index.
- REQ-014 IDLE: when rx_s==0, SHALL go to START and load cnt=half-1.
- REQ-015 START: at cnt==0, SHALL sample rx_s; 0 -> DATA with cnt=scale-1 and index 0; 1 -> IDLE (glitch, no flag).
- REQ-016 DATA: at each cnt==0, SHALL shift rx_s into bit [index] of a shift register and reload cnt=scale-1; after index 7 go to PARITY if the macro is defined, else to STOP.
- REQ-017 STOP: at cnt==0 with rx_s==1, SHALL commit the byte to the output register and go to IDLE; with rx_s==0, SHALL pulse frame_err, discard the byte and go to RECOVER.
- REQ-018 RECOVER: SHALL stay until rx_s==1, then go to IDLE.
- REQ-019 Commit with valid==0, or valid && ready in the same cycle, SHALL load data and set valid=1 on the next clock (no overrun).
- REQ-020 Commit with valid && !ready SHALL keep the old data, keep valid=1 and pulse overrun.
- REQ-021 valid && ready without a commit SHALL clear valid on the next clock; data stays unchanged.
- REQ-022 Latency: valid SHALL rise 1 clock after the stop-bit sample point, which lies half + 9*scale (+scale with parity) clocks after rx_s falls.
- REQ-023 Sample points SHALL be at bit centres; cnt SHALL decrement every cycle outside IDLE and RECOVER.

Reset
- REQ-024 rst SHALL force state IDLE, cnt 0, index 0, synchronizer 1, valid 0, data 8'h00, frame_err 0, overrun 0, parity_err 0.
- REQ-025 rst asserted mid-frame SHALL abandon the frame without flags; a new start bit is detected only after rst is released and rx_s==0.

Configuration
- REQ-026 Macro UART_RX_PARITY_EN defined: frame SHALL be 8E1; PARITY samples one bit at cnt==0; on mismatch with even parity it pulses parity_err at the stop-bit sample point and does not commit the byte, stop-bit handling otherwise unchanged.
- REQ-027 Macro undefined: SHALL skip PARITY (frame 8N1) and tie parity_err to 0.

Structure
- REQ-028 Shared package uart_pkg SHALL hold the rx state enum and a function computing scale from clk_mhz and boadrate; the transmitter uses the same function.
- REQ-029 The synchronizer SHALL be a sub-module uart_rx_sync (2-FF, parameterized reset value).

Verification (clk_mhz=1, boadrate=100000 -> scale=10, half=5)
- REQ-030 Bytes 8'hA5 then 8'h3C sent with ready=1 -> valid pulses with data A5, then 3C; no flags.
- REQ-031 rx low for 3 clocks then high -> returns to IDLE, valid stays 0, no flags.
- REQ-032 8'h55 with stop bit 0, then line high, then 8'h12 -> frame_err pulses once; only 12 is delivered.
- REQ-033 With ready=0, send 8'h01 then 8'h02 -> data stays 01, overrun pulses once at the second commit; raise ready -> 01 is consumed, valid falls.
- REQ-034 rst asserted during bit 4 of 8'hFF, released, then 8'h81 sent -> only 81 is delivered, no flags.
- REQ-035 Loopback: uart_tx_writer (same parameters) tx drives rx for bytes 00, FF, 5A -> received in order; with UART_RX_PARITY_EN, a wrong parity bit sent for 5A -> parity_err, no valid.
